pipe_hazard_ctl: RTL and testbench

Parametrised hazard and forwarding controller for the five-stage pipelined CPU, sitting beside the decoder in the D stage. It forwards E and M stage results to the D-stage operand muxes and detects load-use hazards. It adds a multi-cycle multiply/divide (MDU) tracker that stalls dependent HI/LO readers and back-to-back MDU operations. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctl_if.sv | 41 ++++
 rtl/pipe_hazard_ctl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctl_if.sv
// Hazard-controller bundle: D-stage decode info and E/M-stage destination info
// going in, with forward selects, stall controls and MDU status coming back.
interface pipe_hazard_ctl_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 32
);
    logic [AW-1:0]    rs;
    logic [AW-1:0]    rt;
    logic             d_use_rs;
    logic             d_use_rt;
    logic             d_mdu_start;
    logic             d_mdu_div;
    logic             d_use_hilo;
    logic             ewreg;
    logic             em2reg;
    logic [AW-1:0]    ern;
    logic             mwreg;
    logic             mm2reg;
    logic [AW-1:0]    mrn;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             wpcir;
    logic             bubble;
    logic             mdu_busy;
    logic             mdu_done;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: drives decode/stage info, consumes hazard decisions
    modport master (
        output rs, rt, d_use_rs, d_use_rt, d_mdu_start, d_mdu_div, d_use_hilo,
        output ewreg, em2reg, ern, mwreg, mm2reg, mrn,
        input  fwda, fwdb, wpcir, bubble, mdu_busy, mdu_done, stall_cnt
    );

    // Controller side
    modport slave (
        input  rs, rt, d_use_rs, d_use_rt, d_mdu_start, d_mdu_div, d_use_hilo,
        input  ewreg, em2reg, ern, mwreg, mm2reg, mrn,
        output fwda, fwdb, wpcir, bubble, mdu_busy, mdu_done, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// Hazard and forwarding controller for the five-stage pipeline (D stage).
// Forwards E/M results to the D operand muxes, stalls on load-use, tracks the
// multi-cycle multiply/divide unit to hold HI/LO readers and back-to-back MDU
// ops, and counts stalled cycles in a saturating counter.
module pipe_hazard_ctl #(
    parameter int AW      = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             resetn,
    pipe_hazard_ctl_if.slave hz
);

    // MDU down-counter wide enough for the longer of the two latencies
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int MW      = $clog2(MAX_LAT + 1);

    localparam logic [MW-1:0]    MUL_LOAD  = MW'(MUL_LAT);
    localparam logic [MW-1:0]    DIV_LOAD  = MW'(DIV_LAT);
    localparam logic [MW-1:0]    CNT_ZERO  = {MW{1'b0}};
    localparam logic [MW-1:0]    CNT_ONE   = MW'(1'b1);
    localparam logic [AW-1:0]    REG_ZERO  = {AW{1'b0}};
    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1'b1);

    // Forward select for one source register. E-stage ALU results win over
    // M-stage ones because they are younger; a load still in E cannot forward.
    // Register 0 is hard-wired zero and never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] src,
        input logic          e_wreg,
        input logic          e_m2reg,
        input logic [AW-1:0] e_rn,
        input logic          m_wreg,
        input logic          m_m2reg,
        input logic [AW-1:0] m_rn
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src == REG_ZERO) begin
            sel = 2'b00;
        end else if (e_wreg && !e_m2reg && (e_rn == src)) begin
            sel = 2'b01;
        end else if (m_wreg && !m_m2reg && (m_rn == src)) begin
            sel = 2'b10;
        end else if (m_wreg && m_m2reg && (m_rn == src)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    logic [1:0]       fwda_s;
    logic [1:0]       fwdb_s;
    logic             load_use_s;
    logic             mdu_busy_s;
    logic             mdu_done_s;
    logic             mdu_stall_s;
    logic             stall_s;
    logic             mdu_accept_s;
    logic [MW-1:0]    cnt_d;
    logic [MW-1:0]    cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    // Operand forward selects, rs and rt evaluated independently
    always_comb begin
        fwda_s = fwd_sel(hz.rs, hz.ewreg, hz.em2reg, hz.ern,
                         hz.mwreg, hz.mm2reg, hz.mrn);
        fwdb_s = fwd_sel(hz.rt, hz.ewreg, hz.em2reg, hz.ern,
                         hz.mwreg, hz.mm2reg, hz.mrn);
    end

    // Hazard detection: load-use and MDU-busy stalls, and MDU accept
    always_comb begin
        load_use_s = 1'b0;
        if (hz.ewreg && hz.em2reg && (hz.ern != REG_ZERO)) begin
            load_use_s = (hz.d_use_rs && (hz.ern == hz.rs)) ||
                         (hz.d_use_rt && (hz.ern == hz.rt));
        end else begin
            load_use_s = 1'b0;
        end
        mdu_busy_s   = (cnt_q != CNT_ZERO);
        mdu_done_s   = (cnt_q == CNT_ONE);
        // A start in the done cycle still waits, so operations never overlap
        mdu_stall_s  = mdu_busy_s && (hz.d_use_hilo || hz.d_mdu_start);
        stall_s      = load_use_s || mdu_stall_s;
        // A stalled MDU op stays in D and is re-evaluated next cycle
        mdu_accept_s = hz.d_mdu_start && !stall_s;
    end

    // Next MDU busy count: load on accept, otherwise count down to idle
    always_comb begin
        cnt_d = cnt_q;
        if (mdu_accept_s) begin
            cnt_d = hz.d_mdu_div ? DIV_LOAD : MUL_LOAD;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Next stall-cycle count, saturating at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers; reset aborts any MDU operation in flight
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q       <= CNT_ZERO;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.fwda      = fwda_s;
    assign hz.fwdb      = fwdb_s;
    assign hz.wpcir     = ~stall_s;
    assign hz.bubble    = stall_s;
    assign hz.mdu_busy  = mdu_busy_s;
    assign hz.mdu_done  = mdu_done_s;
    assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl. A 32-bit-counter instance and a
// 4-bit-counter instance see identical stimulus; the narrow one shows the
// stall counter saturating. Expected values come from hand-derived control
// vectors and a bench-side count of expected stall cycles.
module tb_pipe_hazard_ctl;

    logic clock;
    logic resetn;

    pipe_hazard_ctl_if #(.AW(5), .CNT_W(32)) bus ();
    pipe_hazard_ctl_if #(.AW(5), .CNT_W(4))  bus4 ();

    pipe_hazard_ctl #(.AW(5), .MUL_LAT(4), .DIV_LAT(16), .CNT_W(32)) dut (
        .clock  (clock),
        .resetn (resetn),
        .hz     (bus)
    );

    pipe_hazard_ctl #(.AW(5), .MUL_LAT(4), .DIV_LAT(16), .CNT_W(4)) dut_sat (
        .clock  (clock),
        .resetn (resetn),
        .hz     (bus4)
    );

    // Narrow instance mirrors the main stimulus
    assign bus4.rs          = bus.rs;
    assign bus4.rt          = bus.rt;
    assign bus4.d_use_rs    = bus.d_use_rs;
    assign bus4.d_use_rt    = bus.d_use_rt;
    assign bus4.d_mdu_start = bus.d_mdu_start;
    assign bus4.d_mdu_div   = bus.d_mdu_div;
    assign bus4.d_use_hilo  = bus.d_use_hilo;
    assign bus4.ewreg       = bus.ewreg;
    assign bus4.em2reg      = bus.em2reg;
    assign bus4.ern         = bus.ern;
    assign bus4.mwreg       = bus.mwreg;
    assign bus4.mm2reg      = bus.mm2reg;
    assign bus4.mrn         = bus.mrn;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One cycle of D/E/M stage state plus the expected control vector
    // ctl = {fwda, fwdb, wpcir, bubble, mdu_busy, mdu_done}
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       start;
        logic       div;
        logic       hilo;
        logic       ewreg;
        logic       em2reg;
        logic [4:0] ern;
        logic       mwreg;
        logic       mm2reg;
        logic [4:0] mrn;
        logic [7:0] ctl;
    } stim_t;

    localparam stim_t IDLE = '{ctl: 8'h08, default: '0};

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_stalls = 0;
    logic [43:0] sb[$];
    logic [43:0] exp_v;
    logic [43:0] obs_s;

    assign obs_s = {bus.fwda, bus.fwdb, bus.wpcir, bus.bubble, bus.mdu_busy,
                    bus.mdu_done, bus.stall_cnt, bus4.stall_cnt};

    function automatic logic [43:0] mk_exp(input logic [7:0] ctl);
        logic [3:0] sat;
        sat = (exp_stalls > 15) ? 4'hF : 4'(exp_stalls);
        return {ctl, 32'(exp_stalls), sat};
    endfunction

    task automatic apply(input stim_t s);
        bus.rs          = s.rs;
        bus.rt          = s.rt;
        bus.d_use_rs    = s.use_rs;
        bus.d_use_rt    = s.use_rt;
        bus.d_mdu_start = s.start;
        bus.d_mdu_div   = s.div;
        bus.d_use_hilo  = s.hilo;
        bus.ewreg       = s.ewreg;
        bus.em2reg      = s.em2reg;
        bus.ern         = s.ern;
        bus.mwreg       = s.mwreg;
        bus.mm2reg      = s.mm2reg;
        bus.mrn         = s.mrn;
    endtask

    task automatic test_reset();
        stim_t q[$];
        stim_t s;
        resetn = 1'b0;
        q.push_back(IDLE);
        s = IDLE; s.ewreg = 1'b1; s.em2reg = 1'b1; s.ern = 5'd5; s.rt = 5'd5;
        s.use_rt = 1'b1; s.ctl = 8'h04;
        q.push_back(s);
        q.push_back(IDLE);
        foreach (q[k]) begin
            @(negedge clock);
            apply(q[k]);
            sb.push_back(mk_exp(q[k].ctl));
            #1;
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin
                n_bad++;
                $display("FAIL reset[%0d] got=%h want=%h", k, obs_s, exp_v);
            end
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_forward();
        stim_t q[$];
        stim_t s;
        s = IDLE; s.ewreg = 1'b1; s.ern = 5'd3; s.mwreg = 1'b1; s.mm2reg = 1'b1;
        s.mrn = 5'd3; s.rs = 5'd3; s.rt = 5'd3; s.ctl = 8'h58;
        q.push_back(s);
        s.ewreg = 1'b0; s.ctl = 8'hF8;
        q.push_back(s);
        s = IDLE; s.ewreg = 1'b1; s.ern = 5'd3; s.mwreg = 1'b1; s.mrn = 5'd7;
        s.rs = 5'd7; s.rt = 5'd3; s.ctl = 8'h98;
        q.push_back(s);
        s = IDLE; s.ewreg = 1'b1; s.ern = 5'd4; s.mwreg = 1'b1; s.mrn = 5'd4;
        s.rs = 5'd4; s.rt = 5'd9; s.ctl = 8'h48;
        q.push_back(s);
        s = IDLE; s.ewreg = 1'b1; s.mwreg = 1'b1; s.mm2reg = 1'b1; s.ctl = 8'h08;
        q.push_back(s);
        s = IDLE; s.ewreg = 1'b1; s.em2reg = 1'b1; s.ern = 5'd2; s.rs = 5'd2;
        s.mwreg = 1'b1; s.mrn = 5'd2; s.ctl = 8'h88;
        q.push_back(s);
        foreach (q[k]) begin
            @(negedge clock);
            apply(q[k]);
            sb.push_back(mk_exp(q[k].ctl));
            #1;
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin
                n_bad++;
                $display("FAIL forward[%0d] got=%h want=%h", k, obs_s, exp_v);
            end
            if (q[k].ctl[2]) exp_stalls++;
        end
    endtask

    task automatic test_load_use();
        stim_t q[$];
        stim_t s;
        s = IDLE; s.ewreg = 1'b1; s.em2reg = 1'b1; s.ern = 5'd5; s.rt = 5'd5;
        s.use_rt = 1'b1; s.rs = 5'd2; s.ctl = 8'h04;
        q.push_back(s);
        s = IDLE; s.mwreg = 1'b1; s.mm2reg = 1'b1; s.mrn = 5'd5; s.rt = 5'd5;
        s.use_rt = 1'b1; s.rs = 5'd2; s.ctl = 8'h38;
        q.push_back(s);
        s = IDLE; s.ewreg = 1'b1; s.em2reg = 1'b1; s.ern = 5'd5; s.rt = 5'd5;
        s.ctl = 8'h08;
        q.push_back(s);
        s = IDLE; s.ewreg = 1'b1; s.em2reg = 1'b1; s.ern = 5'd5; s.rs = 5'd5;
        s.use_rs = 1'b1; s.rt = 5'd1; s.ctl = 8'h04;
        q.push_back(s);
        s = IDLE; s.ewreg = 1'b1; s.em2reg = 1'b1; s.use_rt = 1'b1; s.ctl = 8'h08;
        q.push_back(s);
        foreach (q[k]) begin
            @(negedge clock);
            apply(q[k]);
            sb.push_back(mk_exp(q[k].ctl));
            #1;
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin
                n_bad++;
                $display("FAIL load_use[%0d] got=%h want=%h", k, obs_s, exp_v);
            end
            if (q[k].ctl[2]) exp_stalls++;
        end
    endtask

    task automatic test_mult_mfhi();
        stim_t q[$];
        stim_t s;
        s = IDLE; s.start = 1'b1;
        q.push_back(s);
        for (int i = 0; i < 4; i++) begin
            s = IDLE; s.hilo = 1'b1; s.ctl = (i == 3) ? 8'h07 : 8'h06;
            q.push_back(s);
        end
        s = IDLE; s.hilo = 1'b1;
        q.push_back(s);
        foreach (q[k]) begin
            @(negedge clock);
            apply(q[k]);
            sb.push_back(mk_exp(q[k].ctl));
            #1;
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin
                n_bad++;
                $display("FAIL mult_mfhi[%0d] got=%h want=%h", k, obs_s, exp_v);
            end
            if (q[k].ctl[2]) exp_stalls++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t q[$];
        stim_t s;
        s = IDLE; s.start = 1'b1; s.div = 1'b1;
        q.push_back(s);
        for (int i = 0; i < 16; i++) begin
            s = IDLE; s.start = 1'b1; s.ctl = (i == 15) ? 8'h07 : 8'h06;
            q.push_back(s);
        end
        s = IDLE; s.start = 1'b1;
        q.push_back(s);
        for (int i = 0; i < 4; i++) begin
            s = IDLE; s.ctl = (i == 3) ? 8'h0B : 8'h0A;
            q.push_back(s);
        end
        q.push_back(IDLE);
        foreach (q[k]) begin
            @(negedge clock);
            apply(q[k]);
            sb.push_back(mk_exp(q[k].ctl));
            #1;
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin
                n_bad++;
                $display("FAIL back_to_back[%0d] got=%h want=%h", k, obs_s, exp_v);
            end
            if (q[k].ctl[2]) exp_stalls++;
        end
    endtask

    task automatic test_priority();
        stim_t q[$];
        stim_t s;
        s = IDLE; s.start = 1'b1; s.ewreg = 1'b1; s.em2reg = 1'b1; s.ern = 5'd6;
        s.rs = 5'd6; s.use_rs = 1'b1; s.ctl = 8'h04;
        q.push_back(s);
        s = IDLE; s.start = 1'b1; s.mwreg = 1'b1; s.mm2reg = 1'b1; s.mrn = 5'd6;
        s.rs = 5'd6; s.use_rs = 1'b1; s.ctl = 8'hC8;
        q.push_back(s);
        for (int i = 0; i < 4; i++) begin
            s = IDLE; s.ctl = (i == 3) ? 8'h0B : 8'h0A;
            q.push_back(s);
        end
        q.push_back(IDLE);
        foreach (q[k]) begin
            @(negedge clock);
            apply(q[k]);
            sb.push_back(mk_exp(q[k].ctl));
            #1;
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin
                n_bad++;
                $display("FAIL priority[%0d] got=%h want=%h", k, obs_s, exp_v);
            end
            if (q[k].ctl[2]) exp_stalls++;
        end
    endtask

    task automatic test_reset_mid_div();
        stim_t q[$];
        stim_t s;
        s = IDLE; s.start = 1'b1; s.div = 1'b1;
        q.push_back(s);
        for (int i = 0; i < 3; i++) begin
            s = IDLE; s.hilo = 1'b1; s.ctl = 8'h06;
            q.push_back(s);
        end
        foreach (q[k]) begin
            @(negedge clock);
            apply(q[k]);
            sb.push_back(mk_exp(q[k].ctl));
            #1;
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin
                n_bad++;
                $display("FAIL reset_mid_div[%0d] got=%h want=%h", k, obs_s, exp_v);
            end
            if (q[k].ctl[2]) exp_stalls++;
        end
        // Reader still waiting in D; reset lands between clock edges
        @(negedge clock);
        s = IDLE; s.hilo = 1'b1;
        apply(s);
        #1;
        resetn = 1'b0;
        exp_stalls = 0;
        sb.push_back(mk_exp(8'h08));
        #1;
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs_s !== exp_v) begin
            n_bad++;
            $display("FAIL reset_abort got=%h want=%h", obs_s, exp_v);
        end
        @(negedge clock);
        resetn = 1'b1;
        sb.push_back(mk_exp(8'h08));
        #1;
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs_s !== exp_v) begin
            n_bad++;
            $display("FAIL reset_release got=%h want=%h", obs_s, exp_v);
        end
    endtask

    task automatic test_saturation();
        stim_t q[$];
        stim_t s;
        for (int i = 0; i < 21; i++) begin
            s = IDLE; s.ewreg = 1'b1; s.em2reg = 1'b1; s.ern = 5'd7; s.rt = 5'd7;
            s.use_rt = 1'b1; s.ctl = 8'h04;
            q.push_back(s);
        end
        q.push_back(IDLE);
        q.push_back(IDLE);
        foreach (q[k]) begin
            @(negedge clock);
            apply(q[k]);
            sb.push_back(mk_exp(q[k].ctl));
            #1;
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin
                n_bad++;
                $display("FAIL saturation[%0d] got=%h want=%h", k, obs_s, exp_v);
            end
            if (q[k].ctl[2]) exp_stalls++;
        end
    endtask

    initial begin
        resetn = 1'b0;
        apply(IDLE);
        test_reset();
        test_forward();
        test_load_use();
        test_mult_mfhi();
        test_back_to_back();
        test_priority();
        test_reset_mid_div();
        test_saturation();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
